// File: rtl/ram_access_ctrl.sv
// Load/store front-end for an 8192x32 byte-enabled synchronous data RAM.
// Converts CPU byte/half/word requests into word address, active-low lane
// selects and lane-replicated write data. Returns aligned, extended load data
// with a one-cycle ack. Misaligned or illegal requests are flagged without
// touching the RAM.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-3:0] ram_address,
  output logic [31:0]       ram_din,
  output logic              ram_rnw,
  output logic [3:0]        ram_cs_b,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [1:0]        lo_q, lo_d;
  logic [ADDR_W-3:0] ram_address_q, ram_address_d;
  logic [31:0]       ram_din_q, ram_din_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              illegal;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  // Request qualification: accepted only in IDLE; illegal size or misalignment
  always_comb begin
    accept  = (state_q == IDLE) && req;
    illegal = (size == 2'b11) ||
              ((size == 2'b01) && addr[0]) ||
              ((size == 2'b10) && (addr[1:0] != 2'b00));
  end

  // State register
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = illegal ? IDLE : ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM-side outputs decode only from registered state, never from CPU inputs
  always_comb begin
    ready    = (state_q == IDLE);
    ram_rnw  = 1'b1;
    ram_cs_b = '1;
    if (state_q == ACCESS) begin
      ram_rnw = ~we_q;
      if (we_q) begin
        case (size_q)
          2'b00:   ram_cs_b = ~(4'b0001 << lo_q);
          2'b01:   ram_cs_b = lo_q[1] ? 4'b0011 : 4'b1100;
          default: ram_cs_b = '0;
        endcase
      end
    end
  end

  // Lane extraction (little-endian) and zero/sign extension of load data
  always_comb begin
    case (lo_q)
      2'd0:    byte_sel = ram_dout[7:0];
      2'd1:    byte_sel = ram_dout[15:8];
      2'd2:    byte_sel = ram_dout[23:16];
      default: byte_sel = ram_dout[31:24];
    endcase
    half_sel = lo_q[1] ? ram_dout[31:16] : ram_dout[15:0];
    case (size_q)
      2'b00:   load_data = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_data = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_data = ram_dout;
    endcase
  end

  // Datapath next values: capture on acceptance, ack/err/rdata on completion
  always_comb begin
    we_d          = we_q;
    size_d        = size_q;
    sext_d        = sext_q;
    lo_d          = lo_q;
    ram_address_d = ram_address_q;
    ram_din_d     = ram_din_q;
    rdata_d       = rdata_q;
    ack_d         = 1'b0;
    err_d         = 1'b0;
    if (accept) begin
      we_d          = we;
      size_d        = size;
      sext_d        = sext;
      lo_d          = addr[1:0];
      ram_address_d = addr[ADDR_W-1:2];
      case (size)
        2'b00:   ram_din_d = {4{wdata[7:0]}};
        2'b01:   ram_din_d = {2{wdata[15:0]}};
        default: ram_din_d = wdata;
      endcase
      ack_d = illegal;
      err_d = illegal;
    end else if ((state_q == ACCESS) && we_q) begin
      ack_d = 1'b1;
    end else if (state_q == RDATA) begin
      ack_d   = 1'b1;
      rdata_d = load_data;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      we_q          <= 1'b0;
      size_q        <= '0;
      sext_q        <= 1'b0;
      lo_q          <= '0;
      ram_address_q <= '0;
      ram_din_q     <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      we_q          <= we_d;
      size_q        <= size_d;
      sext_q        <= sext_d;
      lo_q          <= lo_d;
      ram_address_q <= ram_address_d;
      ram_din_q     <= ram_din_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign ram_address = ram_address_q;
  assign ram_din     = ram_din_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 8192x32 byte-enabled
// synchronous RAM attached to the RAM-side ports.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        req;
  logic        ready;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [14:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;
  logic [12:0] ram_address;
  logic [31:0] ram_din;
  logic        ram_rnw;
  logic [3:0]  ram_cs_b;
  logic [31:0] ram_dout;

  logic        ram_clr;
  logic [31:0] mem [8192];

  int checks = 0;
  int errors = 0;

  ram_access_ctrl #(.ADDR_W(15)) dut (
    .clk(clk), .reset_b(reset_b), .req(req), .ready(ready), .we(we),
    .size(size), .sext(sext), .addr(addr), .wdata(wdata), .ack(ack),
    .err(err), .rdata(rdata), .ram_address(ram_address), .ram_din(ram_din),
    .ram_rnw(ram_rnw), .ram_cs_b(ram_cs_b), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: byte-lane writes, registered read every edge
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (!ram_rnw) begin
      for (int i = 0; i < 4; i++)
        if (!ram_cs_b[i]) mem[ram_address][8*i +: 8] <= ram_din[8*i +: 8];
    end
    ram_dout <= mem[ram_address];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for ready, pass the accepting edge E0
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [14:0] a, input logic [31:0] wd);
    int n;
    we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    chk("issue_ready", 32'(ready), 32'd1);
    tick();
    req = 1'b0;
  endtask

  task automatic do_store(input logic [14:0] a, input logic [1:0] sz, input logic [31:0] wd,
                          input logic [3:0] ecs, input logic [31:0] edin);
    issue(1'b1, sz, 1'b0, a, wd);
    chk("st_ready_low", 32'(ready), 32'd0);
    chk("st_cs_b", 32'(ram_cs_b), 32'(ecs));
    chk("st_rnw", 32'(ram_rnw), 32'd0);
    chk("st_address", 32'(ram_address), 32'(a[14:2]));
    chk("st_din", ram_din, edin);
    chk("st_ack_early", 32'(ack), 32'd0);
    tick();
    chk("st_ack", 32'(ack), 32'd1);
    chk("st_err", 32'(err), 32'd0);
    chk("st_cs_idle", 32'(ram_cs_b), 32'hF);
    tick();
    chk("st_ack_pulse", 32'(ack), 32'd0);
  endtask

  task automatic do_load(input logic [14:0] a, input logic [1:0] sz, input logic sx,
                         input logic [31:0] exp);
    issue(1'b0, sz, sx, a, 32'h0);
    chk("ld_cs_b", 32'(ram_cs_b), 32'hF);
    chk("ld_rnw", 32'(ram_rnw), 32'd1);
    chk("ld_ready_low", 32'(ready), 32'd0);
    chk("ld_address", 32'(ram_address), 32'(a[14:2]));
    tick();
    chk("ld_rdata_ready", 32'(ready), 32'd0);
    chk("ld_ack_early", 32'(ack), 32'd0);
    tick();
    chk("ld_ack", 32'(ack), 32'd1);
    chk("ld_err", 32'(err), 32'd0);
    chk("ld_rdata", rdata, exp);
    tick();
    chk("ld_ack_pulse", 32'(ack), 32'd0);
    chk("ld_rdata_hold", rdata, exp);
  endtask

  task automatic do_err(input logic w, input logic [1:0] sz, input logic [14:0] a,
                        input logic [31:0] prev);
    issue(w, sz, 1'b1, a, 32'hA5A5_A5A5);
    chk("er_ack", 32'(ack), 32'd1);
    chk("er_err", 32'(err), 32'd1);
    chk("er_ready", 32'(ready), 32'd1);
    chk("er_cs_b", 32'(ram_cs_b), 32'hF);
    chk("er_rdata", rdata, prev);
    tick();
    chk("er_ack_pulse", 32'(ack), 32'd0);
    chk("er_err_clr", 32'(err), 32'd0);
    chk("er_cs_b_after", 32'(ram_cs_b), 32'hF);
  endtask

  initial begin
    logic [7:0] ack_exp;
    logic [7:0] ready_exp;
    reset_b = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = '0; wdata = '0; ram_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_address", 32'(ram_address), 32'h0);
    chk("rst_din", ram_din, 32'h0);
    chk("rst_cs_b", 32'(ram_cs_b), 32'hF);
    chk("rst_rnw", 32'(ram_rnw), 32'd1);
    @(negedge clk);
    reset_b = 1'b1;
    ram_clr = 1'b0;
    tick();

    // Word store/load at 0x0010 (word 4)
    do_store(15'h0010, 2'b10, 32'hDEAD_BEEF, 4'b0000, 32'hDEAD_BEEF);
    chk("addr_word4", 32'(ram_address), 32'h004);
    do_load(15'h0010, 2'b10, 1'b0, 32'hDEAD_BEEF);

    // Byte store into lane 3 of word 4; upper wdata bits must be ignored
    do_store(15'h0013, 2'b00, 32'h1234_5680, 4'b0111, 32'h8080_8080);
    do_load(15'h0013, 2'b00, 1'b1, 32'hFFFF_FF80);
    do_load(15'h0013, 2'b00, 1'b0, 32'h0000_0080);
    do_load(15'h0010, 2'b10, 1'b0, 32'h80AD_BEEF);

    // Halfwords in word 8
    do_store(15'h0022, 2'b01, 32'hFFFF_1234, 4'b0011, 32'h1234_1234);
    do_load(15'h0022, 2'b01, 1'b0, 32'h0000_1234);
    do_store(15'h0020, 2'b01, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
    do_load(15'h0020, 2'b01, 1'b1, 32'hFFFF_BEEF);
    do_load(15'h0023, 2'b00, 1'b1, 32'h0000_0012);
    do_load(15'h0020, 2'b10, 1'b0, 32'h1234_BEEF);

    // Misaligned / illegal requests
    do_err(1'b0, 2'b01, 15'h0001, 32'h1234_BEEF);
    do_err(1'b0, 2'b10, 15'h0002, 32'h1234_BEEF);
    do_err(1'b1, 2'b11, 15'h0000, 32'h1234_BEEF);
    do_load(15'h0010, 2'b10, 1'b0, 32'h80AD_BEEF);

    // Back-to-back with req held: store, load, store
    // ack expected after edges E1, E4, E6; ready after E1, E4, E6, E7
    ack_exp   = 8'h52;
    ready_exp = 8'hD2;
    we = 1'b1; size = 2'b10; sext = 1'b0; addr = 15'h0040; wdata = 32'hCAFE_F00D;
    req = 1'b1;
    chk("b2b_ready0", 32'(ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2b_ack", 32'(ack), 32'(ack_exp[k]));
      chk("b2b_ready", 32'(ready), 32'(ready_exp[k]));
      if (k == 0) begin
        we = 1'b0; size = 2'b10; addr = 15'h0040;
      end else if (k == 2) begin
        we = 1'b1; size = 2'b10; addr = 15'h0044; wdata = 32'h55AA_55AA;
      end else if (k == 4) begin
        chk("b2b_rdata", rdata, 32'hCAFE_F00D);
      end else if (k == 5) begin
        req = 1'b0;
      end
    end
    do_load(15'h0044, 2'b10, 1'b0, 32'h55AA_55AA);

    // Reset during ACCESS of a store: store is lost
    issue(1'b1, 2'b10, 1'b0, 15'h0010, 32'hFFFF_FFFF);
    chk("rs_cs_access", 32'(ram_cs_b), 32'h0);
    #1;
    reset_b = 1'b0;
    #1;
    chk("rs_cs_b", 32'(ram_cs_b), 32'hF);
    chk("rs_ack", 32'(ack), 32'd0);
    chk("rs_rnw", 32'(ram_rnw), 32'd1);
    chk("rs_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    tick();
    chk("rs_ready", 32'(ready), 32'd1);
    do_load(15'h0010, 2'b10, 1'b0, 32'h80AD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
